// File: rtl/pe_pad_ctl.sv
// Pad sequencer for a 1-D convolution PE: loads input/weight pads over rdy/ack,
// walks output/tap indices to drive pad reads and MAC control, then hands off each psum.
module pe_pad_ctl #(
    parameter int unsigned IPAD_DEPTH = 12,
    parameter int unsigned WPAD_DEPTH = 12,
    parameter int unsigned AW         = 4,
    parameter int unsigned MAC_LAT    = 2
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_start,
    input  logic [AW-1:0] i_ilen,
    input  logic [AW-1:0] i_flen,
    input  logic          i_Input_rdy,
    output logic          o_Input_ack,
    input  logic          i_Weight_rdy,
    output logic          o_Weight_ack,
    output logic          o_ipad_write,
    output logic [AW-1:0] o_ipad_waddr,
    output logic          o_wpad_write,
    output logic [AW-1:0] o_wpad_waddr,
    output logic          o_ipad_read,
    output logic [AW-1:0] o_ipad_raddr,
    output logic          o_wpad_read,
    output logic [AW-1:0] o_wpad_raddr,
    output logic          o_mac_first,
    output logic          o_mac_last,
    output logic          o_Psum_rdy,
    input  logic          i_Psum_ack,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_err
);

    localparam int unsigned DW = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_COMPUTE,
        S_DRAIN,
        S_OUTPUT
    } state_t;

    state_t        r_state;
    logic [AW-1:0] r_ilen;
    logic [AW-1:0] r_flen;
    logic [AW-1:0] r_icnt;
    logic [AW-1:0] r_fcnt;
    logic [AW-1:0] r_o;
    logic [AW-1:0] r_k;
    logic [DW-1:0] r_dcnt;

    logic          r_input_ack;
    logic          r_weight_ack;
    logic          r_ipad_write;
    logic [AW-1:0] r_ipad_waddr;
    logic          r_wpad_write;
    logic [AW-1:0] r_wpad_waddr;
    logic          r_ipad_read;
    logic [AW-1:0] r_ipad_raddr;
    logic          r_wpad_read;
    logic [AW-1:0] r_wpad_raddr;
    logic          r_mac_first;
    logic          r_mac_last;
    logic          r_psum_rdy;
    logic          r_busy;
    logic          r_done;
    logic          r_err;

    logic          w_cfg_ok;
    logic          w_in_xfer;
    logic          w_wt_xfer;
    logic          w_psum_xfer;
    logic [AW-1:0] w_icnt_nx;
    logic [AW-1:0] w_fcnt_nx;
    logic          w_loaded;
    logic [AW-1:0] w_k_inc;
    logic [AW-1:0] w_o_inc;
    logic          w_last_tap;
    logic          w_last_out;
    logic          w_drain_end;

    // Config legality and handshake qualification, all from registered acks
    assign w_cfg_ok    = (i_flen != '0) && (i_flen <= i_ilen) &&
                         (32'(i_ilen) <= IPAD_DEPTH) && (32'(i_flen) <= WPAD_DEPTH);
    assign w_in_xfer   = (r_state == S_LOAD) && i_Input_rdy && r_input_ack;
    assign w_wt_xfer   = (r_state == S_LOAD) && i_Weight_rdy && r_weight_ack;
    assign w_psum_xfer = (r_state == S_OUTPUT) && i_Psum_ack && r_psum_rdy;

    assign w_icnt_nx   = w_in_xfer ? r_icnt + AW'(1) : r_icnt;
    assign w_fcnt_nx   = w_wt_xfer ? r_fcnt + AW'(1) : r_fcnt;
    assign w_loaded    = (w_icnt_nx == r_ilen) && (w_fcnt_nx == r_flen);
    assign w_k_inc     = r_k + AW'(1);
    assign w_o_inc     = r_o + AW'(1);
    assign w_last_tap  = (r_k == r_flen - AW'(1));
    assign w_last_out  = (r_o == r_ilen - r_flen);
    assign w_drain_end = (r_dcnt == DW'(MAC_LAT - 1));

    // State, counters and every output register; outputs reflect the state being entered
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= S_IDLE;
            r_ilen       <= '0;
            r_flen       <= '0;
            r_icnt       <= '0;
            r_fcnt       <= '0;
            r_o          <= '0;
            r_k          <= '0;
            r_dcnt       <= '0;
            r_input_ack  <= 1'b0;
            r_weight_ack <= 1'b0;
            r_ipad_write <= 1'b0;
            r_ipad_waddr <= '0;
            r_wpad_write <= 1'b0;
            r_wpad_waddr <= '0;
            r_ipad_read  <= 1'b0;
            r_ipad_raddr <= '0;
            r_wpad_read  <= 1'b0;
            r_wpad_raddr <= '0;
            r_mac_first  <= 1'b0;
            r_mac_last   <= 1'b0;
            r_psum_rdy   <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_ipad_write <= w_in_xfer;
            r_ipad_waddr <= w_in_xfer ? r_icnt : '0;
            r_wpad_write <= w_wt_xfer;
            r_wpad_waddr <= w_wt_xfer ? r_fcnt : '0;
            r_input_ack  <= 1'b0;
            r_weight_ack <= 1'b0;
            r_ipad_read  <= 1'b0;
            r_ipad_raddr <= '0;
            r_wpad_read  <= 1'b0;
            r_wpad_raddr <= '0;
            r_mac_first  <= 1'b0;
            r_mac_last   <= 1'b0;
            r_psum_rdy   <= 1'b0;
            r_busy       <= 1'b1;
            r_done       <= 1'b0;
            r_err        <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    r_busy <= 1'b0;
                    if (i_start) begin
                        if (w_cfg_ok) begin
                            r_state      <= S_LOAD;
                            r_ilen       <= i_ilen;
                            r_flen       <= i_flen;
                            r_icnt       <= '0;
                            r_fcnt       <= '0;
                            r_o          <= '0;
                            r_k          <= '0;
                            r_dcnt       <= '0;
                            r_input_ack  <= 1'b1;
                            r_weight_ack <= 1'b1;
                            r_busy       <= 1'b1;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end

                S_LOAD: begin
                    r_icnt <= w_icnt_nx;
                    r_fcnt <= w_fcnt_nx;
                    if (w_loaded) begin
                        r_state      <= S_COMPUTE;
                        r_o          <= '0;
                        r_k          <= '0;
                        r_ipad_read  <= 1'b1;
                        r_wpad_read  <= 1'b1;
                        r_mac_first  <= 1'b1;
                        r_mac_last   <= (r_flen == AW'(1));
                    end else begin
                        r_input_ack  <= (w_icnt_nx < r_ilen);
                        r_weight_ack <= (w_fcnt_nx < r_flen);
                    end
                end

                S_COMPUTE: begin
                    if (w_last_tap) begin
                        r_state <= S_DRAIN;
                        r_dcnt  <= '0;
                    end else begin
                        r_k          <= w_k_inc;
                        r_ipad_read  <= 1'b1;
                        r_wpad_read  <= 1'b1;
                        r_ipad_raddr <= r_o + w_k_inc;
                        r_wpad_raddr <= w_k_inc;
                        r_mac_last   <= (w_k_inc == r_flen - AW'(1));
                    end
                end

                S_DRAIN: begin
                    if (w_drain_end) begin
                        r_state    <= S_OUTPUT;
                        r_psum_rdy <= 1'b1;
                    end else begin
                        r_dcnt <= r_dcnt + DW'(1);
                    end
                end

                S_OUTPUT: begin
                    if (!w_psum_xfer) begin
                        r_psum_rdy <= 1'b1;
                    end else if (w_last_out) begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                    end else begin
                        // Next output window starts at tap 0 of the shifted input slice
                        r_state      <= S_COMPUTE;
                        r_o          <= w_o_inc;
                        r_k          <= '0;
                        r_ipad_read  <= 1'b1;
                        r_wpad_read  <= 1'b1;
                        r_ipad_raddr <= w_o_inc;
                        r_mac_first  <= 1'b1;
                        r_mac_last   <= (r_flen == AW'(1));
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_Input_ack  = r_input_ack;
    assign o_Weight_ack = r_weight_ack;
    assign o_ipad_write = r_ipad_write;
    assign o_ipad_waddr = r_ipad_waddr;
    assign o_wpad_write = r_wpad_write;
    assign o_wpad_waddr = r_wpad_waddr;
    assign o_ipad_read  = r_ipad_read;
    assign o_ipad_raddr = r_ipad_raddr;
    assign o_wpad_read  = r_wpad_read;
    assign o_wpad_raddr = r_wpad_raddr;
    assign o_mac_first  = r_mac_first;
    assign o_mac_last   = r_mac_last;
    assign o_Psum_rdy   = r_psum_rdy;
    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_err        = r_err;

endmodule

// File: tb/tb_pe_pad_ctl.sv
// Randomized bench for pe_pad_ctl: a transaction-level model builds each job's tap list
// and timing expectations from the length/latency rules and checks every cycle.
module tb_pe_pad_ctl;

    localparam int unsigned IPAD_DEPTH = 12;
    localparam int unsigned WPAD_DEPTH = 12;
    localparam int unsigned AW         = 4;
    localparam int unsigned MAC_LAT    = 2;

    logic          clk = 1'b0;
    logic          i_rst;
    logic          i_start;
    logic [AW-1:0] i_ilen;
    logic [AW-1:0] i_flen;
    logic          i_Input_rdy;
    logic          o_Input_ack;
    logic          i_Weight_rdy;
    logic          o_Weight_ack;
    logic          o_ipad_write;
    logic [AW-1:0] o_ipad_waddr;
    logic          o_wpad_write;
    logic [AW-1:0] o_wpad_waddr;
    logic          o_ipad_read;
    logic [AW-1:0] o_ipad_raddr;
    logic          o_wpad_read;
    logic [AW-1:0] o_wpad_raddr;
    logic          o_mac_first;
    logic          o_mac_last;
    logic          o_Psum_rdy;
    logic          i_Psum_ack;
    logic          o_busy;
    logic          o_done;
    logic          o_err;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pe_pad_ctl #(
        .IPAD_DEPTH(IPAD_DEPTH),
        .WPAD_DEPTH(WPAD_DEPTH),
        .AW        (AW),
        .MAC_LAT   (MAC_LAT)
    ) dut (
        .i_clk       (clk),
        .i_rst       (i_rst),
        .i_start     (i_start),
        .i_ilen      (i_ilen),
        .i_flen      (i_flen),
        .i_Input_rdy (i_Input_rdy),
        .o_Input_ack (o_Input_ack),
        .i_Weight_rdy(i_Weight_rdy),
        .o_Weight_ack(o_Weight_ack),
        .o_ipad_write(o_ipad_write),
        .o_ipad_waddr(o_ipad_waddr),
        .o_wpad_write(o_wpad_write),
        .o_wpad_waddr(o_wpad_waddr),
        .o_ipad_read (o_ipad_read),
        .o_ipad_raddr(o_ipad_raddr),
        .o_wpad_read (o_wpad_read),
        .o_wpad_raddr(o_wpad_raddr),
        .o_mac_first (o_mac_first),
        .o_mac_last  (o_mac_last),
        .o_Psum_rdy  (o_Psum_rdy),
        .i_Psum_ack  (i_Psum_ack),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_err       (o_err)
    );

    function automatic logic [63:0] outs();
        return 64'({o_Input_ack, o_Weight_ack, o_ipad_write, o_ipad_waddr, o_wpad_write,
                    o_wpad_waddr, o_ipad_read, o_ipad_raddr, o_wpad_read, o_wpad_raddr,
                    o_mac_first, o_mac_last, o_Psum_rdy, o_busy, o_done, o_err});
    endfunction

    task automatic idle_inputs();
        i_start      = 1'b0;
        i_ilen       = '0;
        i_flen       = '0;
        i_Input_rdy  = 1'b0;
        i_Weight_rdy = 1'b0;
        i_Psum_ack   = 1'b0;
    endtask

    // One job; model tracks loads, tap order, drain length and psum handoff at transaction level
    task automatic run_job(input int il, input int fl, input int in_pct, input int in_per,
                           input int w_pct, input int ack_d, input bit noisy);
        int ra_q[$];
        int wa_q[$];
        bit f_q[$];
        bit l_q[$];
        int in_x, w_x, iw_exp, ww_exp, psums, nout, drain_left, pcyc, cyc;
        int e_ra, e_wa;
        bit e_f, e_l;
        bit pend_iw, pend_ww, exp_read, in_psum, exp_done, xi, xw, xp, loaded_before;

        nout = il - fl + 1;
        for (int o = 0; o < nout; o++) begin
            for (int k = 0; k < fl; k++) begin
                ra_q.push_back(o + k);
                wa_q.push_back(k);
                f_q.push_back(k == 0);
                l_q.push_back(k == fl - 1);
            end
        end
        in_x = 0; w_x = 0; iw_exp = 0; ww_exp = 0; psums = 0; drain_left = 0;
        pcyc = 0; cyc = 0; e_ra = 0; e_wa = 0; e_f = 0; e_l = 0;
        pend_iw = 0; pend_ww = 0; exp_read = 0; in_psum = 0; exp_done = 0;

        idle_inputs();
        i_ilen  = AW'(il);
        i_flen  = AW'(fl);
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;

        forever begin
            n_vec++;
            if ({o_done, o_busy} !== {exp_done, !exp_done}) begin
                n_err++;
                $display("FAIL done_busy cyc=%0d: got done=%b busy=%b want done=%b", cyc, o_done, o_busy, exp_done);
            end
            n_vec++;
            if (o_err !== 1'b0) begin
                n_err++;
                $display("FAIL err_in_job cyc=%0d: got %b want 0", cyc, o_err);
            end
            n_vec++;
            if ({o_Input_ack, o_Weight_ack} !== {in_x < il, w_x < fl}) begin
                n_err++;
                $display("FAIL acks cyc=%0d: got %b%b want %b%b", cyc, o_Input_ack, o_Weight_ack, in_x < il, w_x < fl);
            end
            n_vec++;
            if ({o_ipad_write, o_wpad_write} !== {pend_iw, pend_ww}) begin
                n_err++;
                $display("FAIL writes cyc=%0d: got %b%b want %b%b", cyc, o_ipad_write, o_wpad_write, pend_iw, pend_ww);
            end
            if (pend_iw) begin
                n_vec++;
                if (o_ipad_waddr !== AW'(iw_exp)) begin
                    n_err++;
                    $display("FAIL ipad_waddr: got %0d want %0d", o_ipad_waddr, iw_exp);
                end
                iw_exp++;
            end
            if (pend_ww) begin
                n_vec++;
                if (o_wpad_waddr !== AW'(ww_exp)) begin
                    n_err++;
                    $display("FAIL wpad_waddr: got %0d want %0d", o_wpad_waddr, ww_exp);
                end
                ww_exp++;
            end
            n_vec++;
            if ({o_ipad_read, o_wpad_read, o_Psum_rdy} !== {exp_read, exp_read, in_psum}) begin
                n_err++;
                $display("FAIL read_psum cyc=%0d: got rd=%b%b prdy=%b want rd=%b prdy=%b", cyc, o_ipad_read, o_wpad_read, o_Psum_rdy, exp_read, in_psum);
            end
            if (exp_read && ra_q.size() > 0) begin
                e_ra = ra_q.pop_front();
                e_wa = wa_q.pop_front();
                e_f  = f_q.pop_front();
                e_l  = l_q.pop_front();
                n_vec++;
                if ({o_ipad_raddr, o_wpad_raddr, o_mac_first, o_mac_last} !== {AW'(e_ra), AW'(e_wa), e_f, e_l}) begin
                    n_err++;
                    $display("FAIL tap cyc=%0d: got ia=%0d wa=%0d f=%b l=%b want ia=%0d wa=%0d f=%b l=%b", cyc, o_ipad_raddr, o_wpad_raddr, o_mac_first, o_mac_last, e_ra, e_wa, e_f, e_l);
                end
            end
            if (exp_done) begin
                n_vec++;
                if (ra_q.size() != 0 || psums != nout || iw_exp != il || ww_exp != fl) begin
                    n_err++;
                    $display("FAIL job_totals il=%0d fl=%0d: taps_left=%0d psums=%0d/%0d iw=%0d ww=%0d", il, fl, ra_q.size(), psums, nout, iw_exp, ww_exp);
                end
                break;
            end
            cyc++;
            if (cyc > 4000) begin
                n_vec++;
                n_err++;
                $display("FAIL timeout il=%0d fl=%0d: got no o_done within 4000 cycles", il, fl);
                break;
            end

            // Drive next inputs
            if (in_per > 0) i_Input_rdy = (cyc % in_per == 0);
            else            i_Input_rdy = (int'($urandom_range(99)) < in_pct);
            i_Weight_rdy = (int'($urandom_range(99)) < w_pct);
            if (in_psum) begin
                pcyc++;
                i_Psum_ack = (pcyc >= ack_d);
            end else begin
                i_Psum_ack = noisy ? 1'($urandom_range(1)) : 1'b0;
            end
            if (noisy) begin
                i_start = 1'($urandom_range(1));
                i_ilen  = AW'($urandom);
                i_flen  = AW'($urandom);
            end

            // Advance model for the coming edge
            xi = i_Input_rdy && (in_x < il);
            xw = i_Weight_rdy && (w_x < fl);
            xp = in_psum && i_Psum_ack;
            loaded_before = (in_x == il) && (w_x == fl);
            pend_iw = xi;
            pend_ww = xw;
            in_x += int'(xi);
            w_x  += int'(xw);
            if (!loaded_before && in_x == il && w_x == fl) begin
                exp_read = 1'b1;
            end else if (exp_read) begin
                if (e_l) begin
                    exp_read   = 1'b0;
                    drain_left = MAC_LAT;
                end
            end else if (drain_left > 0) begin
                drain_left--;
                if (drain_left == 0) begin
                    in_psum = 1'b1;
                    pcyc    = 0;
                end
            end else if (xp) begin
                in_psum = 1'b0;
                psums++;
                if (psums < nout) exp_read = 1'b1;
                else              exp_done = 1'b1;
            end
            @(negedge clk);
        end
        idle_inputs();
    endtask

    task automatic test_reset();
        idle_inputs();
        i_rst        = 1'b1;
        i_start      = 1'b1;
        i_ilen       = AW'(5);
        i_flen       = AW'(3);
        i_Input_rdy  = 1'b1;
        i_Weight_rdy = 1'b1;
        i_Psum_ack   = 1'b1;
        repeat (2) @(negedge clk);
        n_vec++;
        if (outs() !== 64'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got %h want 0", outs());
        end
        i_rst = 1'b0;
        idle_inputs();
        @(negedge clk);
        n_vec++;
        if (outs() !== 64'd0) begin
            n_err++;
            $display("FAIL idle_outputs: got %h want 0", outs());
        end
    endtask

    task automatic test_basic();
        run_job(5, 3, 100, 0, 100, 1, 1'b0);
    endtask

    task automatic test_single();
        run_job(1, 1, 100, 0, 100, 1, 1'b0);
    endtask

    task automatic test_bad_config();
        int cfg_i[5] = '{3, 5, 13, 0, 12};
        int cfg_f[5] = '{4, 0, 3, 0, 13};
        for (int c = 0; c < 5; c++) begin
            idle_inputs();
            i_start      = 1'b1;
            i_ilen       = AW'(cfg_i[c]);
            i_flen       = AW'(cfg_f[c]);
            i_Input_rdy  = 1'b1;
            i_Weight_rdy = 1'b1;
            @(negedge clk);
            n_vec++;
            if ({o_err, o_busy, o_Input_ack, o_Weight_ack} !== 4'b1000) begin
                n_err++;
                $display("FAIL bad_cfg_pulse il=%0d fl=%0d: got %b want 1000", cfg_i[c], cfg_f[c], {o_err, o_busy, o_Input_ack, o_Weight_ack});
            end
            i_start = 1'b0;
            @(negedge clk);
            n_vec++;
            if ({o_err, o_busy, o_Input_ack, o_Weight_ack} !== 4'b0000) begin
                n_err++;
                $display("FAIL bad_cfg_after il=%0d fl=%0d: got %b want 0000", cfg_i[c], cfg_f[c], {o_err, o_busy, o_Input_ack, o_Weight_ack});
            end
        end
        idle_inputs();
    endtask

    task automatic test_psum_delay();
        run_job(4, 2, 100, 0, 100, 5, 1'b0);
    endtask

    task automatic test_trickle();
        run_job(5, 3, 0, 3, 100, 1, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_job(3, 3, 100, 0, 100, 1, 1'b0);
        run_job(12, 12, 100, 0, 100, 2, 1'b0);
        run_job(12, 1, 70, 0, 70, 1, 1'b1);
    endtask

    task automatic test_random();
        int il, fl;
        for (int n = 0; n < 10; n++) begin
            il = int'($urandom_range(12, 1));
            fl = int'($urandom_range(il, 1));
            run_job(il, fl, int'($urandom_range(100, 30)), 0, int'($urandom_range(100, 30)),
                    int'($urandom_range(4, 1)), 1'b1);
        end
    endtask

    task automatic test_reset_mid();
        int waited;
        idle_inputs();
        i_ilen       = AW'(6);
        i_flen       = AW'(2);
        i_start      = 1'b1;
        i_Input_rdy  = 1'b1;
        i_Weight_rdy = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        waited  = 0;
        while (o_ipad_read !== 1'b1 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        n_vec++;
        if (o_ipad_read !== 1'b1) begin
            n_err++;
            $display("FAIL mid_compute_reach: got read=%b want 1 within 50 cycles", o_ipad_read);
        end
        i_rst      = 1'b1;
        i_start    = 1'b1;
        i_Psum_ack = 1'b1;
        @(negedge clk);
        n_vec++;
        if (outs() !== 64'd0) begin
            n_err++;
            $display("FAIL mid_reset_outputs: got %h want 0", outs());
        end
        i_rst = 1'b0;
        idle_inputs();
        @(negedge clk);
        n_vec++;
        if (outs() !== 64'd0) begin
            n_err++;
            $display("FAIL post_reset_idle: got %h want 0", outs());
        end
        run_job(4, 2, 100, 0, 100, 1, 1'b0);
    endtask

    initial begin
        idle_inputs();
        i_rst = 1'b1;
        @(negedge clk);
        test_reset();
        test_basic();
        test_single();
        test_bad_config();
        test_psum_delay();
        test_trickle();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pe_pad_ctl.md
PE_PAD_CTL -- requirements
Module: pe_pad_ctl

Interface
REQ-001 SHALL have parameter IPAD_DEPTH, default 12, meaning input-pad word count.
REQ-002 SHALL have parameter WPAD_DEPTH, default 12, meaning weight-pad word count.
REQ-003 SHALL have parameter AW, default 4, meaning pad address and length width; AW >= clog2(max(IPAD_DEPTH, WPAD_DEPTH)+1).
REQ-004 SHALL have parameter MAC_LAT, default 2, meaning cycles from last tap read to psum valid; MAC_LAT >= 1.
REQ-005 SHALL have ports, in order:
- i_clk  in  1  clock; single clock domain, rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_start  in  1  job start; sampled in IDLE only.
- i_ilen  in  AW  input vector length.
- i_flen  in  AW  filter length.
- i_Input_rdy  in  1  input word offered.
- o_Input_ack  out  1  input word accepted.
- i_Weight_rdy  in  1  weight word offered.
- o_Weight_ack  out  1  weight word accepted.
- o_ipad_write  out  1  ipad write strobe.
- o_ipad_waddr  out  AW  ipad write address.
- o_wpad_write  out  1  wpad write strobe.
- o_wpad_waddr  out  AW  wpad write address.
- o_ipad_read  out  1  ipad read strobe.
- o_ipad_raddr  out  AW  ipad read address.
- o_wpad_read  out  1  wpad read strobe.
- o_wpad_raddr  out  AW  wpad read address.
- o_mac_first  out  1  current tap is tap 0; clear accumulator.
- o_mac_last  out  1  current tap is the last tap.
- o_Psum_rdy  out  1  psum valid toward consumer.
- i_Psum_ack  in  1  consumer takes psum.
- o_busy  out  1  state != IDLE.
- o_done  out  1  one-cycle job-complete pulse.
- o_err  out  1  one-cycle bad-config pulse.

Function
REQ-006 Transfer SHALL occur on any rdy/ack port only when rdy and ack are both high at a rising edge.
REQ-007 All outputs SHALL depend only on registered state and counters; there SHALL be no combinational input-to-output path.
REQ-008 FSM states SHALL be IDLE, LOAD, COMPUTE, DRAIN, OUTPUT.
REQ-009 In IDLE, i_start=1 with a legal config SHALL latch ilen and flen, clear all counters, and enter LOAD.
- Legal config: 1 <= flen <= ilen; ilen <= IPAD_DEPTH; flen <= WPAD_DEPTH.
REQ-010 In IDLE, i_start=1 with an illegal config SHALL pulse o_err for one cycle and stay in IDLE.
REQ-011 i_start SHALL be ignored in all states other than IDLE.
REQ-012 In LOAD, o_Input_ack SHALL be high iff the input count < ilen.
- Each input transfer SHALL assert o_ipad_write in that cycle with o_ipad_waddr = current count, then increment the count.
REQ-013 Weights SHALL follow the same rules as REQ-012 against flen, using o_Weight_ack, o_wpad_write and o_wpad_waddr.
- Input and weight transfers in the same cycle SHALL both be accepted.
REQ-014 LOAD SHALL exit to COMPUTE on the edge where both counts have reached their lengths.
REQ-015 COMPUTE SHALL issue one tap per cycle, with output index o (0..ilen-flen) and tap k (0..flen-1).
- o_ipad_read = o_wpad_read = 1.
- o_ipad_raddr = o+k; o_wpad_raddr = k.
- o_mac_first = (k==0); o_mac_last = (k==flen-1).
REQ-016 After the tap with k = flen-1, the FSM SHALL enter DRAIN for exactly MAC_LAT cycles, then enter OUTPUT.
REQ-017 In OUTPUT, o_Psum_rdy SHALL be held high until i_Psum_ack=1.
- No pad reads SHALL be issued while in OUTPUT.
REQ-018 On the psum transfer, if o < ilen-flen the FSM SHALL set o=o+1, k=0 and return to COMPUTE.
REQ-019 On the psum transfer for the last output, the FSM SHALL pulse o_done for one cycle and enter IDLE.
REQ-020 i_Psum_ack SHALL be ignored outside OUTPUT; rdy inputs SHALL be ignored outside LOAD.
REQ-021 Read addresses SHALL never exceed ilen-1 (ipad) or flen-1 (wpad); counters SHALL NOT wrap.

Reset
REQ-022 On i_rst=1 at a rising edge, from any state including mid-job, the block SHALL enter IDLE and clear all counters and latched lengths.
REQ-023 After reset, every output SHALL be 0 (all strobes, acks, rdy, busy, done, err and addresses).
REQ-024 i_rst SHALL take priority over i_start and all handshake inputs in the same cycle.

Verification
REQ-025 Stimulus: ilen=5, flen=3, all rdy held high, Psum ack immediate. Required response:
- 5 input and 3 weight writes.
- ipad raddr sequence 0,1,2,1,2,3,2,3,4; wpad raddr 0,1,2 repeated.
- 3 psums, then o_done.
REQ-026 Stimulus: ilen=1, flen=1. Required response: one tap with first=last=1, 2 DRAIN cycles, one psum, o_done.
REQ-027 Stimulus: ilen=3, flen=4 (also flen=0 and ilen=13). Required response: o_err pulse, o_busy stays 0, no ack ever raised.
REQ-028 Stimulus: i_Psum_ack delayed 5 cycles. Required response: o_Psum_rdy held 5 cycles, no reads, counters frozen.
REQ-029 Stimulus: weights finish early, inputs trickle in every 3rd cycle. Required response: o_Weight_ack drops after 3 words; COMPUTE starts only after the 5th input.
REQ-030 Stimulus: i_rst mid-COMPUTE. Required response: next cycle all outputs 0 and state IDLE; a new i_start runs a clean job.
